// File: rtl/fastclkdiv_pkg.sv
// ---------------------------------------------------------------------------
// fastclkdiv_pkg
// Shared definitions for the fastclkdiv_pwm tick generator:
//   state_t          - FSM state encoding (ST_IDLE, ST_RUN)
//   num_stages       - number of cascaded counter slices for a given width
//   last_stage_width - width of the top (possibly narrower) counter slice
// ---------------------------------------------------------------------------
package fastclkdiv_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int num_stages(input int nbits, input int stage_bits);
        return (nbits + stage_bits - 1) / stage_bits;
    endfunction

    function automatic int last_stage_width(input int nbits, input int stage_bits);
        return nbits - (num_stages(nbits, stage_bits) - 1) * stage_bits;
    endfunction

endpackage

// File: rtl/fastclkdiv_pwm_if.sv
// ---------------------------------------------------------------------------
// fastclkdiv_pwm_if
// Control/status bundle of the fastclkdiv_pwm tick generator.
//   i_en, i_start, i_stop, i_oneshot, i_shadow_wr, i_period, i_cmp : to DUT
//   o_q, o_tc, o_pwm, o_running                                    : from DUT
// modport master : the controlling side (drives the i_* signals)
// modport slave  : the divider itself (drives the o_* signals)
// ---------------------------------------------------------------------------
interface fastclkdiv_pwm_if #(
    parameter int NBITS = 16
);
    logic             i_en;
    logic             i_start;
    logic             i_stop;
    logic             i_oneshot;
    logic             i_shadow_wr;
    logic [NBITS-1:0] i_period;
    logic [NBITS-1:0] i_cmp;
    logic [NBITS-1:0] o_q;
    logic             o_tc;
    logic             o_pwm;
    logic             o_running;

    modport master (
        output i_en, i_start, i_stop, i_oneshot, i_shadow_wr, i_period, i_cmp,
        input  o_q, o_tc, o_pwm, o_running
    );

    modport slave (
        input  i_en, i_start, i_stop, i_oneshot, i_shadow_wr, i_period, i_cmp,
        output o_q, o_tc, o_pwm, o_running
    );
endinterface

// File: rtl/fastclkdiv_stage.sv
// ---------------------------------------------------------------------------
// fastclkdiv_stage
// One narrow slice of the cascaded down-counter.
//   i_clk      : clock
//   i_rst_n    : synchronous active-low reset (value 0, zero flag 1)
//   i_load     : load i_load_val (has priority over i_dec)
//   i_load_val : slice of the value to load
//   i_dec      : decrement this slice (borrow-in from the stage below)
//   o_q        : current slice value
//   o_zero     : registered "slice == 0" flag
// ---------------------------------------------------------------------------
module fastclkdiv_stage #(
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_q,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q;
    logic             zero;

    // The zero flag is computed one step ahead (q == 1 before a decrement)
    // so the cascade never needs a wide compare in the critical path.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            q    <= '0;
            zero <= 1'b1;
        end else if (i_load) begin
            q    <= i_load_val;
            zero <= (i_load_val == '0);
        end else if (i_dec) begin
            q    <= q - ONE;
            zero <= (q == ONE);
        end
    end

    assign o_q    = q;
    assign o_zero = zero;

endmodule

// File: rtl/fastclkdiv_pwm.sv
// ---------------------------------------------------------------------------
// fastclkdiv_pwm
// Programmable clock-enable divider with double-buffered period/compare,
// one-shot or auto-reload operation and a registered PWM output.
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset
//   bus     : fastclkdiv_pwm_if.slave
//             i_en (tick qualifier), i_start, i_stop, i_oneshot,
//             i_shadow_wr, i_period (P = period-1), i_cmp (C = high count),
//             o_q (counter), o_tc (terminal count, combinational),
//             o_pwm (registered), o_running (state == RUN)
// ---------------------------------------------------------------------------
module fastclkdiv_pwm
    import fastclkdiv_pkg::*;
#(
    parameter int NBITS       = 16,
    parameter int NBITS_STAGE = 9
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fastclkdiv_pwm_if.slave bus
);

    localparam int NSTAGES = num_stages(NBITS, NBITS_STAGE);
    localparam int LAST_W  = last_stage_width(NBITS, NBITS_STAGE);

    state_t           state_q;
    state_t           state_d;
    logic [NBITS-1:0] shadow_p;
    logic [NBITS-1:0] shadow_c;
    logic [NBITS-1:0] active_c;
    logic [NBITS-1:0] q;
    logic             pwm_q;
    logic [NSTAGES-1:0] zero_flags;
    logic [NSTAGES-1:0] dec_chain;

    logic run;
    logic cnt_zero;
    logic tc;
    logic do_start;
    logic do_reload;
    logic load;
    logic count_en;

    // Counter zero comes only from the registered per-stage flags, so the
    // terminal-count path is a small AND regardless of NBITS.
    always_comb begin
        run       = (state_q == ST_RUN);
        cnt_zero  = &zero_flags;
        tc        = run & bus.i_en & cnt_zero;
        do_start  = ~bus.i_stop & bus.i_start;
        do_reload = ~bus.i_stop & ~bus.i_start & tc & ~bus.i_oneshot;
        load      = do_start | do_reload;
        count_en  = ~bus.i_stop & ~bus.i_start & run & bus.i_en & ~cnt_zero;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop beats start; a one-shot terminal count drops back to IDLE.
    always_comb begin
        state_d = state_q;
        if (bus.i_stop) begin
            state_d = ST_IDLE;
        end else if (bus.i_start) begin
            state_d = ST_RUN;
        end else if (tc && bus.i_oneshot) begin
            state_d = ST_IDLE;
        end
    end

    // Loads read the shadow value from before this edge, so a shadow write
    // colliding with a start/reload only shows up at the following boundary.
    // The active period lives in the counter itself; only C needs a copy.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            shadow_p <= '0;
            shadow_c <= '0;
            active_c <= '0;
        end else begin
            if (bus.i_shadow_wr) begin
                shadow_p <= bus.i_period;
                shadow_c <= bus.i_cmp;
            end
            if (load) begin
                active_c <= shadow_c;
            end
        end
    end

    // Borrow chain: a stage decrements only when every stage below it is
    // zero and the counter as a whole is counting, so lower stages wrap.
    assign dec_chain[0] = count_en;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int W   = (k == NSTAGES - 1) ? LAST_W : NBITS_STAGE;
        localparam int LSB = k * NBITS_STAGE;

        if (k > 0) begin : g_borrow
            assign dec_chain[k] = dec_chain[k-1] & zero_flags[k-1];
        end

        fastclkdiv_stage #(
            .WIDTH (W)
        ) u_stage (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_load     (load),
            .i_load_val (shadow_p[LSB +: W]),
            .i_dec      (dec_chain[k]),
            .o_q        (q[LSB +: W]),
            .o_zero     (zero_flags[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= run & (q < active_c);
        end
    end

    assign bus.o_q       = q;
    assign bus.o_tc      = tc;
    assign bus.o_pwm     = pwm_q;
    assign bus.o_running = run;

endmodule

// File: tb/tb_fastclkdiv_pwm.sv
// ---------------------------------------------------------------------------
// tb_fastclkdiv_pwm
// Directed self-checking bench for fastclkdiv_pwm (NBITS=20, NBITS_STAGE=9).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// before the following rising edge.
// ---------------------------------------------------------------------------
module tb_fastclkdiv_pwm;

    localparam int NBITS = 20;

    logic clk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;
    int   steps;

    always #5 clk = ~clk;

    fastclkdiv_pwm_if #(.NBITS(NBITS)) bus();

    fastclkdiv_pwm #(
        .NBITS       (NBITS),
        .NBITS_STAGE (9)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic oneshot, input logic start,
                                 input logic stop, input logic shadow_wr,
                                 input logic [NBITS-1:0] period, input logic [NBITS-1:0] cmp);
        bus.i_en        = en;
        bus.i_oneshot   = oneshot;
        bus.i_start     = start;
        bus.i_stop      = stop;
        bus.i_shadow_wr = shadow_wr;
        bus.i_period    = period;
        bus.i_cmp       = cmp;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic en_seq [6];
        int   q_seq  [6];
        en_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        q_seq  = '{3, 2, 2, 1, 1, 0};

        // Reset and idle
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 20'd0);
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("idle_q",   32'(bus.o_q),       32'd0);
            checkOutput("idle_tc",  32'(bus.o_tc),      32'd0);
            checkOutput("idle_pwm", 32'(bus.o_pwm),     32'd0);
            checkOutput("idle_run", 32'(bus.o_running), 32'd0);
        end

        // Auto-reload P=4 C=2
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'd4, 20'd2);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'd4, 20'd2);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd4, 20'd2);
        checkOutput("ar_running", 32'(bus.o_running), 32'd1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("ar_q",   32'(bus.o_q),   32'(4 - (i % 5)));
            checkOutput("ar_tc",  32'(bus.o_tc),  32'((i % 5) == 4));
            checkOutput("ar_pwm", 32'(bus.o_pwm), 32'(((i % 5) == 4) || ((i % 5) == 0 && i > 0)));
            if (i < 9) step();
        end
        // Stop on the TC cycle: stop wins over the reload
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'd4, 20'd2);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd4, 20'd2);
        checkOutput("stop_running", 32'(bus.o_running), 32'd0);
        checkOutput("stop_q",       32'(bus.o_q),       32'd0);
        checkOutput("stop_tc",      32'(bus.o_tc),      32'd0);
        checkOutput("stop_pwm_lag", 32'(bus.o_pwm),     32'd1);
        step();
        checkOutput("stop_pwm_low", 32'(bus.o_pwm),     32'd0);

        // Boundary update: P=9 running, P=2 written mid-period
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'd9, 20'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'd9, 20'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd9, 20'd0);
        checkOutput("bnd_q_load", 32'(bus.o_q), 32'd9);
        for (int i = 1; i <= 4; i++) begin
            step();
            checkOutput("bnd_q_dec", 32'(bus.o_q), 32'(9 - i));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'd2, 20'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd2, 20'd0);
        checkOutput("bnd_q_keep", 32'(bus.o_q), 32'd4);
        for (int i = 3; i >= 0; i--) begin
            step();
            checkOutput("bnd_q_tail", 32'(bus.o_q),  32'(i));
            checkOutput("bnd_tc",     32'(bus.o_tc), 32'(i == 0));
        end
        checkOutput("bnd_pwm_c0", 32'(bus.o_pwm), 32'd0);
        // Shadow write in the TC cycle: reload still uses P=2
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'd5, 20'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd5, 20'd0);
        checkOutput("bnd_old_shadow", 32'(bus.o_q), 32'd2);
        step();
        step();
        checkOutput("bnd_short_tc", 32'(bus.o_tc), 32'd1);
        step();
        checkOutput("bnd_new_shadow", 32'(bus.o_q), 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'd5, 20'd0);
        step();

        // One-shot P=3 with gated enable
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 20'd3, 20'd0);
        step();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'd3, 20'd0);
        step();
        checkOutput("os_q_load",  32'(bus.o_q),       32'd3);
        checkOutput("os_running", 32'(bus.o_running), 32'd1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(en_seq[i], 1'b1, 1'b0, 1'b0, 1'b0, 20'd3, 20'd0);
            step();
            checkOutput("os_q",  32'(bus.o_q),  32'(q_seq[i]));
            checkOutput("os_tc", 32'(bus.o_tc), 32'(i == 5));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'd3, 20'd0);
        checkOutput("os_tc_gated", 32'(bus.o_tc), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'd3, 20'd0);
        checkOutput("os_tc_en", 32'(bus.o_tc), 32'd1);
        step();
        checkOutput("os_idle_run", 32'(bus.o_running), 32'd0);
        checkOutput("os_idle_q",   32'(bus.o_q),       32'd0);
        checkOutput("os_idle_tc",  32'(bus.o_tc),      32'd0);
        step();
        checkOutput("os_stay_tc",  32'(bus.o_tc),      32'd0);

        // Multi-stage borrow, P=0x200
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00200, 20'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00200, 20'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00200, 20'd0);
        checkOutput("ms_q_load", 32'(bus.o_q), 32'h200);
        step();
        checkOutput("ms_borrow", 32'(bus.o_q), 32'h1FF);
        steps = 1;
        while (bus.o_tc !== 1'b1 && steps < 2000) begin
            step();
            steps++;
        end
        checkOutput("ms_first_tc", 32'(steps), 32'd512);
        step();
        checkOutput("ms_reload", 32'(bus.o_q), 32'h200);
        steps = 1;
        while (bus.o_tc !== 1'b1 && steps < 2000) begin
            step();
            steps++;
        end
        checkOutput("ms_tc_period", 32'(steps), 32'd513);

        // P=0: terminal count on every enabled tick
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 20'd0, 20'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'd0, 20'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 20'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("p0_tc", 32'(bus.o_tc), 32'd1);
            checkOutput("p0_q",  32'(bus.o_q),  32'd0);
            step();
        end

        // Stop and start together: stop wins
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 20'd0, 20'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 20'd0);
        checkOutput("ss_running", 32'(bus.o_running), 32'd0);
        checkOutput("ss_tc",      32'(bus.o_tc),      32'd0);

        // Restart while running, C > P keeps PWM high
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'd7, 20'd8);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'd7, 20'd8);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd7, 20'd8);
        checkOutput("rs_q_load", 32'(bus.o_q),   32'd7);
        checkOutput("rs_pwm0",   32'(bus.o_pwm), 32'd0);
        step();
        checkOutput("rs_pwm_hi", 32'(bus.o_pwm), 32'd1);
        step();
        checkOutput("rs_q_mid",  32'(bus.o_q),   32'd5);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'd7, 20'd8);
        checkOutput("rs_tc_pre", 32'(bus.o_tc),  32'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd7, 20'd8);
        checkOutput("rs_q_reload", 32'(bus.o_q),       32'd7);
        checkOutput("rs_tc",       32'(bus.o_tc),      32'd0);
        checkOutput("rs_running",  32'(bus.o_running), 32'd1);
        checkOutput("rs_pwm_keep", 32'(bus.o_pwm),     32'd1);
        step();
        checkOutput("rs_q_next",   32'(bus.o_q),       32'd6);

        // Reset mid-period
        rst_n = 1'b0;
        step();
        checkOutput("mr_q",       32'(bus.o_q),       32'd0);
        checkOutput("mr_tc",      32'(bus.o_tc),      32'd0);
        checkOutput("mr_pwm",     32'(bus.o_pwm),     32'd0);
        checkOutput("mr_running", 32'(bus.o_running), 32'd0);
        rst_n = 1'b1;
        step();
        checkOutput("mr_after_run", 32'(bus.o_running), 32'd0);
        checkOutput("mr_after_q",   32'(bus.o_q),       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
